chamber_tree_dispenser: RTL and testbench

Sequential controller for the distribution side of a binary chamber tree. It takes one source inlet and delivers metered pump pulses to one selected leaf chamber out of LEAVES. For each request it opens the valve path from root to leaf, lets the valves settle, and issues N pump pulses. It then closes the path, settles again and reports completion. It sits between the assay scheduler (request handshake) and the valve/pump driver pins of a fan-out chamber network.

---
 rtl/chamber_tree_dispenser.sv | 158 +++++++++++++++
 tb/tb_chamber_tree_dispenser.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/chamber_tree_dispenser.sv
// rtl/chamber_tree_dispenser.sv - root-to-leaf valve path opener and metered pump pulser
// Opens one tree path, issues N pump pulses, closes the path and reports completion.
module chamber_tree_dispenser #(
   parameter int LEAVES     = 8,
   parameter int VOL_W      = 8,
   parameter int PULSE_CYC  = 4,
   parameter int GAP_CYC    = 4,
   parameter int SETTLE_CYC = 2
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_req_valid,
   output logic                       o_req_ready,
   input  logic [$clog2(LEAVES)-1:0]  i_req_leaf,
   input  logic [VOL_W-1:0]           i_req_vol,
   input  logic                       i_abort,
   output logic [2*LEAVES-3:0]        o_valve_en,
   output logic                       o_pump_out,
   output logic [VOL_W-1:0]           o_pulse_cnt,
   output logic                       o_done,
   output logic                       o_done_aborted
);

   localparam int L    = $clog2(LEAVES);
   localparam int EW   = 2*LEAVES - 2;
   localparam int MAXC = (PULSE_CYC > GAP_CYC) ?
                         ((PULSE_CYC > SETTLE_CYC) ? PULSE_CYC : SETTLE_CYC) :
                         ((GAP_CYC > SETTLE_CYC) ? GAP_CYC : SETTLE_CYC);
   localparam int CW   = $clog2(MAXC + 1);

   localparam logic [CW-1:0] SETTLE_RL = CW'(SETTLE_CYC - 1);
   localparam logic [CW-1:0] PULSE_RL  = CW'(PULSE_CYC - 1);
   localparam logic [CW-1:0] GAP_RL    = CW'(GAP_CYC - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_OPEN, S_PUMP_H, S_PUMP_L, S_CLOSE, S_DONE
   } state_t;

   state_t             r_state;
   logic [CW-1:0]      r_cnt;
   logic [VOL_W-1:0]   r_vol;
   logic [EW-1:0]      r_valve_en;
   logic               r_pump;
   logic [VOL_W-1:0]   r_pulse_cnt;
   logic               r_done;
   logic               r_done_aborted;
   logic               r_aborted;

   logic [EW-1:0]      w_path;
   logic [VOL_W-1:0]   w_cnt_next;
   logic               w_abortable;

   // Level l owns edges [2^(l+1)-2, 2^(l+2)-3]; the node hit is the leaf's top l+1 bits.
   for (genvar l = 0; l < L; l++) begin : g_lvl
      for (genvar j = 0; j < (2**(l+1)); j++) begin : g_node
         assign w_path[(2**(l+1)) - 2 + j] = ((i_req_leaf >> (L-1-l)) == L'(j));
      end
   end

   assign w_cnt_next  = r_pulse_cnt + VOL_W'(1);
   assign w_abortable = (r_state == S_OPEN) || (r_state == S_PUMP_H) || (r_state == S_PUMP_L);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state        <= S_IDLE;
         r_cnt          <= '0;
         r_vol          <= '0;
         r_valve_en     <= '0;
         r_pump         <= 1'b0;
         r_pulse_cnt    <= '0;
         r_done         <= 1'b0;
         r_done_aborted <= 1'b0;
         r_aborted      <= 1'b0;
      end else if (i_abort && w_abortable) begin
         r_state    <= S_CLOSE;
         r_cnt      <= SETTLE_RL;
         r_valve_en <= '0;
         r_pump     <= 1'b0;
         r_aborted  <= 1'b1;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_req_valid) begin
                  r_vol       <= i_req_vol;
                  r_pulse_cnt <= '0;
                  r_aborted   <= 1'b0;
                  if (i_req_vol == '0) begin
                     r_state        <= S_DONE;
                     r_done         <= 1'b1;
                     r_done_aborted <= 1'b0;
                  end else begin
                     r_state    <= S_OPEN;
                     r_cnt      <= SETTLE_RL;
                     r_valve_en <= w_path;
                  end
               end
            end
            S_OPEN: begin
               if (r_cnt == '0) begin
                  r_state <= S_PUMP_H;
                  r_cnt   <= PULSE_RL;
                  r_pump  <= 1'b1;
               end else begin
                  r_cnt <= r_cnt - CW'(1);
               end
            end
            S_PUMP_H: begin
               if (r_cnt == '0) begin
                  r_state <= S_PUMP_L;
                  r_cnt   <= GAP_RL;
                  r_pump  <= 1'b0;
               end else begin
                  r_cnt <= r_cnt - CW'(1);
               end
            end
            S_PUMP_L: begin
               if (r_cnt == '0) begin
                  r_pulse_cnt <= w_cnt_next;
                  if (w_cnt_next == r_vol) begin
                     r_state    <= S_CLOSE;
                     r_cnt      <= SETTLE_RL;
                     r_valve_en <= '0;
                  end else begin
                     r_state <= S_PUMP_H;
                     r_cnt   <= PULSE_RL;
                     r_pump  <= 1'b1;
                  end
               end else begin
                  r_cnt <= r_cnt - CW'(1);
               end
            end
            S_CLOSE: begin
               if (r_cnt == '0) begin
                  r_state        <= S_DONE;
                  r_done         <= 1'b1;
                  r_done_aborted <= r_aborted;
               end else begin
                  r_cnt <= r_cnt - CW'(1);
               end
            end
            S_DONE: begin
               r_state        <= S_IDLE;
               r_done         <= 1'b0;
               r_done_aborted <= 1'b0;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_req_ready    = (r_state == S_IDLE);
   assign o_valve_en     = r_valve_en;
   assign o_pump_out     = r_pump;
   assign o_pulse_cnt    = r_pulse_cnt;
   assign o_done         = r_done;
   assign o_done_aborted = r_done_aborted;

endmodule

// File: tb/tb_chamber_tree_dispenser.sv
// tb/tb_chamber_tree_dispenser.sv - directed and random requests against a timeline model
module tb_chamber_tree_dispenser;

   localparam int LEAVES = 8;
   localparam int VOL_W  = 8;
   localparam int P      = 4;
   localparam int G      = 4;
   localparam int S      = 2;
   localparam int L      = $clog2(LEAVES);
   localparam int EW     = 2*LEAVES - 2;
   localparam int CYC    = P + G;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             req_valid = 1'b0;
   logic             abort = 1'b0;
   logic [L-1:0]     req_leaf = '0;
   logic [VOL_W-1:0] req_vol = '0;
   logic             req_ready;
   logic [EW-1:0]    valve_en;
   logic             pump_out;
   logic [VOL_W-1:0] pulse_cnt;
   logic             done;
   logic             done_aborted;

   int n_total = 0;
   int n_pass  = 0;

   chamber_tree_dispenser #(
      .LEAVES(LEAVES), .VOL_W(VOL_W), .PULSE_CYC(P), .GAP_CYC(G), .SETTLE_CYC(S)
   ) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .o_req_ready(req_ready),
      .i_req_leaf(req_leaf), .i_req_vol(req_vol), .i_abort(abort),
      .o_valve_en(valve_en), .o_pump_out(pump_out), .o_pulse_cnt(pulse_cnt),
      .o_done(done), .o_done_aborted(done_aborted)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [EW-1:0] path_of(input int k);
      logic [EW-1:0] p;
      p = '0;
      for (int l = 0; l < L; l++) p[(2**(l+1)) - 2 + (k >> (L-1-l))] = 1'b1;
      return p;
   endfunction

   task automatic chk_idle_zero(input string tag);
      chk({tag, " valve"}, 32'(valve_en), 32'd0);
      chk({tag, " pump"}, 32'(pump_out), 32'd0);
      chk({tag, " done"}, 32'(done), 32'd0);
      chk({tag, " done_ab"}, 32'(done_aborted), 32'd0);
      chk({tag, " cnt"}, 32'(pulse_cnt), 32'd0);
      chk({tag, " ready"}, 32'(req_ready), 32'd1);
   endtask

   // Starts in an IDLE cycle just after sampling; returns in the first IDLE cycle afterwards.
   // da: cycle (1 = first after handshake) in which abort is held high, 0 = none.
   // rst_d: cycle in which rst_n is pulled low, 0 = none.
   task automatic run_req(input int leaf, input int vol, input int da, input int rst_d, input bit hold);
      logic [EW-1:0] path;
      int dend, cf, close_start, m, e_cnt;
      logic e_pump;
      string tg;
      path = path_of(leaf);
      req_valid = 1'b1;
      req_leaf  = L'(leaf);
      req_vol   = VOL_W'(vol);
      if (vol == 0) begin
         close_start = 1; dend = 1; cf = 0;
      end else if (da > 0) begin
         close_start = da + 1; dend = da + 1 + S;
         cf = (da - 1 - S >= 0) ? (da - 1 - S) / CYC : 0;
      end else begin
         close_start = 1 + S + vol*CYC; dend = close_start + S; cf = vol;
      end
      @(posedge clk);
      for (int d = 1; d <= dend + 1; d++) begin
         #1;
         tg = $sformatf("leaf%0d vol%0d d%0d", leaf, vol, d);
         if (rst_d > 0 && d == rst_d + 1) begin
            chk_idle_zero({tg, " rst"});
            rst_n = 1'b1;
            req_valid = 1'b0;
            abort = 1'b0;
            @(posedge clk); #1;
            chk({tg, " rst no done"}, 32'(done), 32'd0);
            chk({tg, " rst ready"}, 32'(req_ready), 32'd1);
            return;
         end
         m      = (d - S - 1 >= 0) ? (d - S - 1) / CYC : 0;
         e_cnt  = (m < cf) ? m : cf;
         e_pump = (vol != 0) && (d < close_start) && (d - 1 - S >= 0) && (((d - 1 - S) % CYC) < P);
         chk({tg, " valve"}, 32'(valve_en), 32'((vol != 0 && d < close_start) ? path : '0));
         chk({tg, " pump"}, 32'(pump_out), 32'(e_pump));
         chk({tg, " cnt"}, 32'(pulse_cnt), 32'(e_cnt));
         chk({tg, " done"}, 32'(done), 32'(d == dend));
         chk({tg, " done_ab"}, 32'(done_aborted), 32'(d == dend && da > 0 && vol != 0));
         chk({tg, " ready"}, 32'(req_ready), 32'(d > dend));
         if (d == 1) begin
            if (!hold) req_valid = 1'b0;
            req_leaf = L'($urandom);
            req_vol  = VOL_W'($urandom);
         end
         // abort noise during CLOSE/DONE must be ignored
         abort = (d == da) || (d >= close_start && d <= dend && d != da && $urandom_range(0, 1) == 1);
         if (rst_d > 0 && d == rst_d) rst_n = 1'b0;
         if (d <= dend) @(posedge clk);
      end
      abort = 1'b0;
      if (!hold) req_valid = 1'b0;
   endtask

   initial begin
      int leaf, vol, da;
      bit hold;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_idle_zero("reset");
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post-reset ready", 32'(req_ready), 32'd1);

      run_req(5, 1, 0, 0, 1'b0);
      run_req(0, 3, 0, 0, 1'b0);
      run_req(7, 200, S + 2*CYC + 2, 0, 1'b0);
      run_req(3, 0, 0, 0, 1'b0);
      run_req(2, 2, 0, 0, 1'b1);
      run_req(6, 1, 0, 0, 1'b0);
      run_req(4, 5, 1, 0, 1'b0);
      run_req(2, 2, S + 2*CYC, 0, 1'b0);
      run_req(4, 3, 0, S + 2, 1'b0);
      run_req(1, 255, 0, 0, 1'b0);

      for (int i = 0; i < 16; i++) begin
         leaf = $urandom_range(0, LEAVES - 1);
         vol  = $urandom_range(0, 5);
         da   = 0;
         if (vol > 0 && $urandom_range(0, 2) == 0) da = $urandom_range(1, S + vol*CYC);
         hold = (i != 15) && ($urandom_range(0, 1) == 1);
         run_req(leaf, vol, da, 0, hold);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
